// File: rtl/lfsr_pkg.sv
// Shared LFSR package: random word width plus the rnd_arbiter FSM states
// and default requester count.
package lfsr_pkg;

   // Width of the LFSR output word (lfsr.rnd_num_o)
   localparam int RND_NUM_W = 8;

   // Default number of random-word consumers sharing the LFSR
   localparam int RND_ARB_N_REQ = 2;

   // rnd_arbiter control states
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_COOL  = 2'd2
   } rnd_arb_state_t;

endpackage : lfsr_pkg

// File: rtl/rnd_rr_pick.sv
// Combinational priority picker for rnd_arbiter.
// Default build: round-robin search starting at ptr, wrapping modulo N.
// With RND_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins
// and ptr is ignored.
module rnd_rr_pick #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     pick,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

`ifdef RND_ARB_FIXED_PRIO_EN
   // The pointer has no meaning with fixed priority.
   logic unused_ptr_s;
   assign unused_ptr_s = ^ptr;

   // Fixed priority: first set bit from index 0 upward wins.
   always_comb begin
      pick = '0;
      idx  = '0;
      any  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req[i]) begin
            any     = 1'b1;
            pick[i] = 1'b1;
            idx     = PTR_W'(i);
         end else begin
            any = any;
         end
      end
   end
`else
   // Round-robin: search ptr, ptr+1, ... wrapping, first set bit wins.
   always_comb begin
      int j;
      j    = 0;
      pick = '0;
      idx  = '0;
      any  = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!any && req[j]) begin
            any     = 1'b1;
            pick[j] = 1'b1;
            idx     = PTR_W'(j);
         end else begin
            any = any;
         end
      end
   end
`endif

endmodule : rnd_rr_pick

// File: rtl/rnd_arbiter.sv
// rnd_arbiter: shares the free-running LFSR word between several consumers.
// One requester is granted at a time with a one-cycle grant pulse and a
// registered snapshot of the LFSR word, then a GAP-cycle cooldown lets the
// LFSR refresh all its bits before the next grant.
// Build option: RND_ARB_FIXED_PRIO_EN selects fixed (lowest index) priority
// instead of round-robin; timing is identical in both builds.
module rnd_arbiter
   import lfsr_pkg::*;
#(
   parameter int N_REQ = RND_ARB_N_REQ,
   parameter int GAP   = RND_NUM_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [RND_NUM_W-1:0] rnd_i,
   input  logic [N_REQ-1:0]     req_i,
   output logic [N_REQ-1:0]     gnt_o,
   output logic [RND_NUM_W-1:0] rnd_o,
   output logic                 busy_o
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(GAP + 1);

   rnd_arb_state_t       state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [N_REQ-1:0]     gnt_q, gnt_d;
   logic [RND_NUM_W-1:0] rnd_q, rnd_d;
   logic [PTR_W-1:0]     ptr_s;

   logic [N_REQ-1:0]     pick_s;
   logic [PTR_W-1:0]     idx_s;
   logic                 any_s;

`ifdef RND_ARB_FIXED_PRIO_EN
   // No rotating pointer with fixed priority.
   assign ptr_s = '0;
`else
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   assign ptr_s = ptr_q;

   // Round-robin pointer: advance past the winner, wrapping to 0.
   always_comb begin
      ptr_d = ptr_q;
      if ((state_q == ARB_IDLE) && any_s) begin
         if (idx_s == PTR_W'(N_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = idx_s + PTR_W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   rnd_rr_pick #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req  (req_i),
      .ptr  (ptr_s),
      .pick (pick_s),
      .idx  (idx_s),
      .any  (any_s)
   );

   // Next-state, cooldown counter, grant and snapshot logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      rnd_d   = rnd_q;
      case (state_q)
         ARB_IDLE: begin
            if (any_s) begin
               gnt_d   = pick_s;
               rnd_d   = rnd_i;
               state_d = ARB_GRANT;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            cnt_d   = CNT_W'(GAP);
            state_d = ARB_COOL;
         end
         ARB_COOL: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = ARB_COOL;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         rnd_q   <= rnd_d;
      end
   end

   assign gnt_o  = gnt_q;
   assign rnd_o  = rnd_q;
   assign busy_o = (state_q != ARB_IDLE);

endmodule : rnd_arbiter

// File: tb/tb_rnd_arbiter.sv
// Directed testbench for rnd_arbiter with N_REQ=2, GAP=4.
// Expectations follow RND_ARB_FIXED_PRIO_EN where the two builds differ.
module tb_rnd_arbiter;

   localparam int N_REQ = 2;
   localparam int GAP   = 4;
   localparam int W     = 8;

   logic          clk_i;
   logic          rst_i;
   logic [W-1:0]  rnd_i;
   logic [1:0]    req_i;
   logic [1:0]    gnt_o;
   logic [W-1:0]  rnd_o;
   logic          busy_o;

   int checks;
   int errors;

   rnd_arbiter #(
      .N_REQ (N_REQ),
      .GAP   (GAP)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .rnd_i  (rnd_i),
      .req_i  (req_i),
      .gnt_o  (gnt_o),
      .rnd_o  (rnd_o),
      .busy_o (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock edge; inputs set before the call are sampled there.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      req_i = 2'b00;
      step();
      rst_i = 1'b0;
   endtask

   // Expect gnt_o == 0 for n cycles (cooldown plus the idle sampling cycle).
   task automatic expect_quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check(tag, {30'd0, gnt_o}, 32'd0);
      end
   endtask

   logic [1:0] exp_second;

   initial begin
      checks = 0;
      errors = 0;
      rst_i  = 1'b1;
      req_i  = 2'b00;
      rnd_i  = 8'h00;
      step();
      step();
      check("rst_gnt",  {30'd0, gnt_o}, 32'd0);
      check("rst_rnd",  {24'd0, rnd_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      rst_i = 1'b0;

      // Single request: grant one cycle, busy for GRANT + GAP cycles.
      step();
      check("idle_gnt", {30'd0, gnt_o}, 32'd0);
      req_i = 2'b01;
      rnd_i = 8'hA5;
      step();
      check("single_gnt",  {30'd0, gnt_o}, 32'd1);
      check("single_rnd",  {24'd0, rnd_o}, 32'hA5);
      check("single_busy", {31'd0, busy_o}, 32'd1);
      req_i = 2'b00;
      for (int i = 0; i < GAP; i++) begin
         rnd_i = 8'h10 + 8'(i);
         step();
         check("cool_gnt",  {30'd0, gnt_o}, 32'd0);
         check("cool_busy", {31'd0, busy_o}, 32'd1);
         check("cool_rnd",  {24'd0, rnd_o}, 32'hA5);
      end
      step();
      check("after_busy", {31'd0, busy_o}, 32'd0);

      // Hold check: rnd_i moves every cycle, no requests.
      for (int i = 0; i < 6; i++) begin
         rnd_i = 8'h3C ^ 8'(i * 37);
         step();
         check("hold_rnd", {24'd0, rnd_o}, 32'hA5);
         check("hold_gnt", {30'd0, gnt_o}, 32'd0);
      end

      // Contention: both request; round-robin alternates, fixed stays on 0.
      do_reset();
      req_i = 2'b11;
      rnd_i = 8'h11;
      step();
      check("cont_gnt1", {30'd0, gnt_o}, 32'd1);
      check("cont_rnd1", {24'd0, rnd_o}, 32'h11);
`ifdef RND_ARB_FIXED_PRIO_EN
      req_i      = 2'b11;
      exp_second = 2'b01;
`else
      req_i      = 2'b10;
      exp_second = 2'b10;
`endif
      rnd_i = 8'h22;
      expect_quiet("cont_gap", GAP + 1);
      step();
      check("cont_gnt2", {30'd0, gnt_o}, {30'd0, exp_second});
      check("cont_rnd2", {24'd0, rnd_o}, 32'h22);
      // Pointer wrapped back to 0: requester 0 wins the next tie.
      req_i = 2'b11;
      rnd_i = 8'h33;
      expect_quiet("cont_gap2", GAP + 1);
      step();
      check("cont_gnt3", {30'd0, gnt_o}, 32'd1);
      check("cont_rnd3", {24'd0, rnd_o}, 32'h33);

      // Request raised during COOL is only served after returning to IDLE.
      do_reset();
      req_i = 2'b01;
      rnd_i = 8'h44;
      step();
      check("cool_req_gnt1", {30'd0, gnt_o}, 32'd1);
      req_i = 2'b10;
      rnd_i = 8'h55;
      expect_quiet("cool_req_quiet", GAP + 1);
      step();
      check("cool_req_gnt2", {30'd0, gnt_o}, 32'd2);
      check("cool_req_rnd2", {24'd0, rnd_o}, 32'h55);
      req_i = 2'b00;

      // Reset mid-COOL: back to reset values, held request re-served.
      do_reset();
      req_i = 2'b01;
      rnd_i = 8'h5A;
      step();
      check("rstc_gnt1", {30'd0, gnt_o}, 32'd1);
      step();
      check("rstc_busy_cool", {31'd0, busy_o}, 32'd1);
      rst_i = 1'b1;
      rnd_i = 8'h66;
      step();
      rst_i = 1'b0;
      check("rstc_gnt",  {30'd0, gnt_o}, 32'd0);
      check("rstc_rnd",  {24'd0, rnd_o}, 32'd0);
      check("rstc_busy", {31'd0, busy_o}, 32'd0);
      rnd_i = 8'h77;
      step();
      check("rstc_regnt", {30'd0, gnt_o}, 32'd1);
      check("rstc_rernd", {24'd0, rnd_o}, 32'h77);
      req_i = 2'b00;
      step();
      check("rstc_pulse", {30'd0, gnt_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rnd_arbiter
